// File: rtl/star_box_drawer.sv
// Traces a square marker around a located star and streams its pixels, one
// per cycle, to the vga_adapter write port. Optional macro: FILL_SQUARE_EN.
module star_box_drawer #(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned SIDE_W   = 3,
  parameter int unsigned COL_W    = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              goDraw,
  input  logic [X_W-1:0]    xIn,
  input  logic [Y_W-1:0]    yIn,
  input  logic [SIDE_W-1:0] side,
  input  logic [COL_W-1:0]  colourIn,
  output logic [X_W-1:0]    vgaX,
  output logic [Y_W-1:0]    vgaY,
  output logic [COL_W-1:0]  vgaColour,
  output logic              plot,
  output logic              doneDraw,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SCAN         = 2'd1,
    DONE         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t            state;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [SIDE_W-1:0] sLen;
  logic [SIDE_W-1:0] dx;
  logic [SIDE_W-1:0] dy;
  logic [COL_W-1:0]  col;

  logic [SIDE_W-1:0] sideEff;
  logic [X_W:0]      px;
  logic [Y_W:0]      py;
  logic              lastX;
  logic              lastY;
  logic              inScreen;
  logic              onBorder;
  logic              drawPix;

  // Pixel coordinates carry one extra bit so off-screen sums are not wrapped.
  assign sideEff  = (side == '0) ? SIDE_W'(1) : side;
  assign px       = {1'b0, x0} + (X_W+1)'(dx);
  assign py       = {1'b0, y0} + (Y_W+1)'(dy);
  assign lastX    = (dx == (sLen - SIDE_W'(1)));
  assign lastY    = (dy == (sLen - SIDE_W'(1)));
  assign inScreen = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));

`ifdef FILL_SQUARE_EN
  assign onBorder = 1'b1;
`else
  assign onBorder = (dx == '0) || lastX || (dy == '0) || lastY;
`endif

  assign drawPix = onBorder && inScreen;

  // Control FSM with registered pixel-port outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      x0        <= '0;
      y0        <= '0;
      sLen      <= '0;
      dx        <= '0;
      dy        <= '0;
      col       <= '0;
      vgaX      <= '0;
      vgaY      <= '0;
      vgaColour <= '0;
      plot      <= 1'b0;
      doneDraw  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot     <= 1'b0;
          doneDraw <= 1'b0;
          if (goDraw) begin
            x0    <= xIn;
            y0    <= yIn;
            sLen  <= sideEff;
            col   <= colourIn;
            dx    <= '0;
            dy    <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          doneDraw <= 1'b0;
          if (!goDraw) begin
            // Request withdrawn: abandon the box without signalling completion.
            plot  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            plot <= drawPix;
            if (drawPix) begin
              vgaX      <= px[X_W-1:0];
              vgaY      <= py[Y_W-1:0];
              vgaColour <= col;
            end
            if (lastX) begin
              dx <= '0;
              if (lastY) begin
                state <= DONE;
              end else begin
                dy <= dy + SIDE_W'(1);
              end
            end else begin
              dx <= dx + SIDE_W'(1);
            end
          end
        end
        DONE: begin
          plot     <= 1'b0;
          doneDraw <= 1'b1;
          busy     <= 1'b0;
          state    <= goDraw ? WAIT_RELEASE : IDLE;
        end
        WAIT_RELEASE: begin
          // A level request still held high must not start a second draw.
          plot     <= 1'b0;
          doneDraw <= 1'b0;
          busy     <= 1'b0;
          if (!goDraw) begin
            state <= IDLE;
          end
        end
        default: begin
          plot     <= 1'b0;
          doneDraw <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_star_box_drawer.sv
// Directed bench for star_box_drawer: outline/fill scans, clipping, side=0,
// abort, mid-scan reset and held-request handling.
module tb_star_box_drawer;

  logic       clk;
  logic       resetn;
  logic       goDraw;
  logic [7:0] xIn;
  logic [6:0] yIn;
  logic [2:0] side;
  logic [2:0] colourIn;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColour;
  logic       plot;
  logic       doneDraw;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

`ifdef FILL_SQUARE_EN
  localparam logic [63:0] MASK_S1 = 64'h1FF;
  localparam logic [63:0] MASK_S2 = 64'h0033;
`else
  localparam logic [63:0] MASK_S1 = 64'h1EF;
  localparam logic [63:0] MASK_S2 = 64'h0013;
`endif

  star_box_drawer dut (
    .clk       (clk),
    .resetn    (resetn),
    .goDraw    (goDraw),
    .xIn       (xIn),
    .yIn       (yIn),
    .side      (side),
    .colourIn  (colourIn),
    .vgaX      (vgaX),
    .vgaY      (vgaY),
    .vgaColour (vgaColour),
    .plot      (plot),
    .doneDraw  (doneDraw),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full accepted draw; mask bit n is the expected plot for scanned pixel n.
  task automatic scanBox(input int x, input int y, input int sideIn, input int sEff,
                         input int c, input logic [63:0] mask);
    xIn      = 8'(x);
    yIn      = 7'(y);
    side     = 3'(sideIn);
    colourIn = 3'(c);
    goDraw   = 1'b1;
    tick();
    check("accept busy", 32'(busy), 1);
    check("accept plot", 32'(plot), 0);
    for (int n = 0; n < sEff * sEff; n++) begin
      tick();
      check($sformatf("plot n=%0d", n), 32'(plot), 32'(mask[n]));
      check($sformatf("busy n=%0d", n), 32'(busy), 1);
      check($sformatf("done n=%0d", n), 32'(doneDraw), 0);
      if (mask[n]) begin
        check($sformatf("vgaX n=%0d", n), 32'(vgaX), 32'(x + n % sEff));
        check($sformatf("vgaY n=%0d", n), 32'(vgaY), 32'(y + n / sEff));
        check($sformatf("colour n=%0d", n), 32'(vgaColour), 32'(c));
      end
    end
    tick();
    check("done pulse", 32'(doneDraw), 1);
    check("done plot", 32'(plot), 0);
    check("done busy", 32'(busy), 0);
    tick();
    check("done cleared", 32'(doneDraw), 0);
    check("after done busy", 32'(busy), 0);
  endtask

  initial begin
    resetn   = 1'b0;
    goDraw   = 1'b0;
    xIn      = '0;
    yIn      = '0;
    side     = '0;
    colourIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst plot", 32'(plot), 0);
    check("rst done", 32'(doneDraw), 0);
    check("rst busy", 32'(busy), 0);
    check("rst vgaX", 32'(vgaX), 0);
    check("rst vgaY", 32'(vgaY), 0);
    check("rst colour", 32'(vgaColour), 0);
    resetn = 1'b1;
    tick();
    check("idle busy", 32'(busy), 0);
    check("idle plot", 32'(plot), 0);

    // Scenario 1 (or 6 with fill): 3x3 at (10,20), request held afterwards.
    scanBox(10, 20, 3, 3, 4, MASK_S1);
    check("hold vgaX", 32'(vgaX), 12);
    check("hold vgaY", 32'(vgaY), 22);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait busy", 32'(busy), 0);
      check("wait plot", 32'(plot), 0);
      check("wait done", 32'(doneDraw), 0);
    end
    goDraw = 1'b0;
    tick();
    check("release busy", 32'(busy), 0);

    // Scenario 2: clipping at the bottom-right corner.
    scanBox(158, 118, 4, 4, 3, MASK_S2);
    goDraw = 1'b0;
    tick();

    // Scenario 3: side 0 behaves as a single pixel.
    scanBox(5, 5, 0, 1, 7, 64'h1);
    goDraw = 1'b0;
    tick();

    // Scenario 4: abort after four plotted pixels, then a fresh draw.
    xIn = 8'd30; yIn = 7'd40; side = 3'd5; colourIn = 3'd2; goDraw = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      tick();
      check("abort-run plot", 32'(plot), 1);
      check("abort-run vgaX", 32'(vgaX), 32'(30 + n));
      check("abort-run vgaY", 32'(vgaY), 40);
    end
    goDraw = 1'b0;
    tick();
    check("abort plot", 32'(plot), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(doneDraw), 0);
    tick();
    check("abort idle plot", 32'(plot), 0);
    check("abort idle done", 32'(doneDraw), 0);
    scanBox(30, 40, 2, 2, 2, 64'hF);
    goDraw = 1'b0;
    tick();

    // Scenario 5: asynchronous reset in the middle of a scan.
    xIn = 8'd0; yIn = 7'd0; side = 3'd7; colourIn = 3'd1; goDraw = 1'b1;
    tick();
    repeat (3) tick();
    check("pre-reset plot", 32'(plot), 1);
    check("pre-reset vgaX", 32'(vgaX), 2);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst plot", 32'(plot), 0);
    check("async rst busy", 32'(busy), 0);
    check("async rst done", 32'(doneDraw), 0);
    check("async rst vgaX", 32'(vgaX), 0);
    goDraw = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-rst plot", 32'(plot), 0);
      check("post-rst busy", 32'(busy), 0);
      check("post-rst done", 32'(doneDraw), 0);
    end
    scanBox(20, 30, 1, 1, 5, 64'h1);
    goDraw = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
